// File: rtl/instr_decode_stage.sv
// MIPS decode to a one-hot class, buffered in a 2-entry FIFO; 1-cycle latency when empty.
// in_ready drops only when both slots are held and downstream is not taking one this cycle.

module instr_decode_fifo2 #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push_i,
   input  logic         pop_i,
   input  logic [W-1:0] wdat_i,
   output logic [W-1:0] rdat_o,
   output logic [1:0]   cnt_o
);

   logic [W-1:0] mem_q [2];
   logic         wr_ptr_q;
   logic         rd_ptr_q;
   logic [1:0]   cnt_q;

   // Caller never pushes when full or pops when empty.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         cnt_q    <= 2'd0;
      end else begin
         if (push_i) begin
            mem_q[wr_ptr_q] <= wdat_i;
            wr_ptr_q        <= ~wr_ptr_q;
         end
         if (pop_i) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         cnt_q <= cnt_q + 2'(push_i) - 2'(pop_i);
      end
   end

   assign rdat_o = mem_q[rd_ptr_q];
   assign cnt_o  = cnt_q;

endmodule

module instr_decode_stage #(
   parameter int EXT_EN = 1,
   parameter int CNT_W  = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      instr_in,
   input  logic [31:0]      pc_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [63:0]      dec_onehot,
   output logic [31:0]      instr_out,
   output logic [31:0]      pc_out,
   output logic             illegal,
   input  logic             cnt_clr,
   output logic [CNT_W-1:0] dec_cnt,
   output logic [CNT_W-1:0] ill_cnt
);

   localparam int         EW       = 64 + 1 + 32 + 32;
   localparam logic [6:0] NO_MATCH = 7'h7f;

   logic [5:0]       op;
   logic [5:0]       funct;
   logic [6:0]       idx;
   logic [63:0]      dec_d;
   logic             ill_d;
   logic             push;
   logic             pop;
   logic [1:0]       occ;
   logic [EW-1:0]    rdat;
   logic             rdy_q;
   logic [CNT_W-1:0] dec_cnt_q, dec_cnt_d;
   logic [CNT_W-1:0] ill_cnt_q, ill_cnt_d;

   assign op    = instr_in[31:26];
   assign funct = instr_in[5:0];

   always_comb begin
      idx = NO_MATCH;
      if (op == 6'h00) begin
         case (funct)
            6'h20: idx = 7'd0;
            6'h21: idx = 7'd1;
            6'h22: idx = 7'd2;
            6'h23: idx = 7'd3;
            6'h24: idx = 7'd4;
            6'h25: idx = 7'd5;
            6'h26: idx = 7'd6;
            6'h27: idx = 7'd7;
            6'h2a: idx = 7'd8;
            6'h2b: idx = 7'd9;
            6'h00: idx = 7'd10;
            6'h02: idx = 7'd11;
            6'h03: idx = 7'd12;
            6'h04: idx = 7'd13;
            6'h06: idx = 7'd14;
            6'h07: idx = 7'd15;
            6'h08: idx = 7'd16;
            6'h09: idx = 7'd31;
            6'h18: idx = 7'd32;
            6'h19: idx = 7'd33;
            6'h1a: idx = 7'd34;
            6'h1b: idx = 7'd35;
            6'h10: idx = 7'd36;
            6'h12: idx = 7'd37;
            6'h11: idx = 7'd38;
            6'h13: idx = 7'd39;
            6'h0c: idx = 7'd40;
            6'h0d: idx = 7'd41;
            default: idx = NO_MATCH;
         endcase
      end else begin
         case (op)
            6'h08: idx = 7'd17;
            6'h09: idx = 7'd18;
            6'h0c: idx = 7'd19;
            6'h0d: idx = 7'd20;
            6'h0e: idx = 7'd21;
            6'h23: idx = 7'd22;
            6'h2b: idx = 7'd23;
            6'h04: idx = 7'd24;
            6'h05: idx = 7'd25;
            6'h0a: idx = 7'd26;
            6'h0b: idx = 7'd27;
            6'h0f: idx = 7'd28;
            6'h02: idx = 7'd29;
            6'h03: idx = 7'd30;
            6'h20: idx = 7'd42;
            6'h24: idx = 7'd43;
            6'h21: idx = 7'd44;
            6'h25: idx = 7'd45;
            6'h28: idx = 7'd46;
            6'h29: idx = 7'd47;
            default: idx = NO_MATCH;
         endcase
      end
      // Extended classes start at bit 31 and vanish entirely when disabled.
      dec_d = '0;
      if (idx != NO_MATCH && (EXT_EN != 0 || idx < 7'd31)) begin
         dec_d[idx[5:0]] = 1'b1;
      end
      ill_d = ~|dec_d;
   end

   assign out_valid = (occ != 2'd0);
   assign in_ready  = rdy_q & ((occ != 2'd2) | out_ready);
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;

   instr_decode_fifo2 #(.W(EW)) u_fifo (
      .clk    (clk),
      .rst_n  (rst_n),
      .push_i (push),
      .pop_i  (pop),
      .wdat_i ({dec_d, ill_d, instr_in, pc_in}),
      .rdat_o (rdat),
      .cnt_o  (occ)
   );

   assign {dec_onehot, illegal, instr_out, pc_out} = rdat;

   always_comb begin
      dec_cnt_d = dec_cnt_q;
      ill_cnt_d = ill_cnt_q;
      if (cnt_clr) begin
         dec_cnt_d = '0;
         ill_cnt_d = '0;
      end else if (pop) begin
         if (dec_cnt_q != '1) dec_cnt_d = dec_cnt_q + CNT_W'(1);
         if (illegal && ill_cnt_q != '1) ill_cnt_d = ill_cnt_q + CNT_W'(1);
      end
   end

   // rdy_q holds in_ready low until the first edge after reset release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdy_q     <= 1'b0;
         dec_cnt_q <= '0;
         ill_cnt_q <= '0;
      end else begin
         rdy_q     <= 1'b1;
         dec_cnt_q <= dec_cnt_d;
         ill_cnt_q <= ill_cnt_d;
      end
   end

   assign dec_cnt = dec_cnt_q;
   assign ill_cnt = ill_cnt_q;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Bench for instr_decode_stage: default instance plus an EXT_EN=0, CNT_W=2 instance,
// directed scenarios, full opcode/funct sweep and a randomized scoreboard run.

module tb_instr_decode_stage;

   logic clk;
   logic rst_n;

   logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_ill, a_cnt_clr;
   logic [31:0] a_instr, a_pc, a_instr_out, a_pc_out;
   logic [63:0] a_dec;
   logic [15:0] a_dec_cnt, a_ill_cnt;

   logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_ill, b_cnt_clr;
   logic [31:0] b_instr, b_pc, b_instr_out, b_pc_out;
   logic [63:0] b_dec;
   logic [1:0]  b_dec_cnt, b_ill_cnt;

   instr_decode_stage u_dut_a (
      .clk(clk), .rst_n(rst_n),
      .in_valid(a_in_valid), .in_ready(a_in_ready), .instr_in(a_instr), .pc_in(a_pc),
      .out_valid(a_out_valid), .out_ready(a_out_ready), .dec_onehot(a_dec),
      .instr_out(a_instr_out), .pc_out(a_pc_out), .illegal(a_ill),
      .cnt_clr(a_cnt_clr), .dec_cnt(a_dec_cnt), .ill_cnt(a_ill_cnt)
   );

   instr_decode_stage #(.EXT_EN(0), .CNT_W(2)) u_dut_b (
      .clk(clk), .rst_n(rst_n),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .instr_in(b_instr), .pc_in(b_pc),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .dec_onehot(b_dec),
      .instr_out(b_instr_out), .pc_out(b_pc_out), .illegal(b_ill),
      .cnt_clr(b_cnt_clr), .dec_cnt(b_dec_cnt), .ill_cnt(b_ill_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   // Encoding table: class bit k matches opcode tab_op[k] and, when tab_fn[k] >= 0, that funct.
   int tab_op [48] = '{
      0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
      'h08, 'h09, 'h0c, 'h0d, 'h0e, 'h23, 'h2b, 'h04, 'h05, 'h0a, 'h0b, 'h0f, 'h02, 'h03,
      0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
      'h20, 'h24, 'h21, 'h25, 'h28, 'h29};
   int tab_fn [48] = '{
      'h20, 'h21, 'h22, 'h23, 'h24, 'h25, 'h26, 'h27, 'h2a, 'h2b, 'h00, 'h02, 'h03, 'h04, 'h06, 'h07, 'h08,
      -1, -1, -1, -1, -1, -1, -1, -1, -1, -1, -1, -1, -1, -1,
      'h09, 'h18, 'h19, 'h1a, 'h1b, 'h10, 'h12, 'h11, 'h13, 'h0c, 'h0d,
      -1, -1, -1, -1, -1, -1};

   function automatic logic [63:0] ref_onehot(input logic [31:0] ins, input bit ext);
      for (int k = 0; k < 48; k++) begin
         if (k >= 31 && !ext) continue;
         if (tab_op[k] == int'(ins[31:26]) && (tab_fn[k] < 0 || tab_fn[k] == int'(ins[5:0])))
            return 64'd1 << k;
      end
      return '0;
   endfunction

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   typedef struct packed {
      logic [63:0] oh;
      logic        ill;
      logic [31:0] instr;
      logic [31:0] pc;
   } exp_t;

   exp_t        sb_q[$];
   exp_t        e;
   logic [31:0] w;
   logic [31:0] i0, i1, i2;
   int unsigned m_dec, m_ill;
   bit          hs_in, hs_out;
   int          k;

   initial begin
      rst_n = 1'b0;
      a_in_valid = 0; a_out_ready = 0; a_cnt_clr = 0; a_instr = 0; a_pc = 0;
      b_in_valid = 0; b_out_ready = 0; b_cnt_clr = 0; b_instr = 0; b_pc = 0;

      // Reset state
      #3;
      check_eq("rst_out_valid", a_out_valid, 0);
      check_eq("rst_in_ready", a_in_ready, 0);
      check_eq("rst_dec", a_dec, 0);
      check_eq("rst_ill", a_ill, 0);
      check_eq("rst_instr_out", a_instr_out, 0);
      check_eq("rst_pc_out", a_pc_out, 0);
      check_eq("rst_dec_cnt", a_dec_cnt, 0);
      check_eq("rst_ill_cnt", a_ill_cnt, 0);
      check_eq("rst_b_in_ready", b_in_ready, 0);
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      #1 check_eq("in_ready_before_edge", a_in_ready, 0);
      tick();
      check_eq("in_ready_after_edge", a_in_ready, 1);

      // add, one-cycle latency, counter
      a_instr = 32'h0022_1820; a_pc = 32'h100; a_in_valid = 1; a_out_ready = 1;
      tick();
      a_in_valid = 0;
      check_eq("add_out_valid", a_out_valid, 1);
      check_eq("add_dec", a_dec, 64'h1);
      check_eq("add_ill", a_ill, 0);
      check_eq("add_instr_out", a_instr_out, 32'h0022_1820);
      check_eq("add_pc_out", a_pc_out, 32'h100);
      tick();
      check_eq("add_dec_cnt", a_dec_cnt, 1);
      check_eq("add_drained", a_out_valid, 0);

      // mult: extended on A, illegal on B
      a_instr = 32'h0022_0018; b_instr = 32'h0022_0018; a_pc = 32'h104; b_pc = 32'h104;
      a_in_valid = 1; b_in_valid = 1; b_out_ready = 1;
      tick();
      a_in_valid = 0; b_in_valid = 0;
      check_eq("mult_a_dec", a_dec, 64'd1 << 32);
      check_eq("mult_a_ill", a_ill, 0);
      check_eq("mult_b_dec", b_dec, 0);
      check_eq("mult_b_ill", b_ill, 1);
      tick();
      check_eq("mult_b_ill_cnt", b_ill_cnt, 1);
      check_eq("mult_b_dec_cnt", b_dec_cnt, 1);
      check_eq("mult_a_ill_cnt", a_ill_cnt, 0);
      check_eq("mult_a_dec_cnt", a_dec_cnt, 2);

      // Backpressure with three back-to-back inputs
      i0 = 32'h0085_1022; i1 = 32'h8C43_0004; i2 = 32'h1022_0003;
      a_out_ready = 0; a_in_valid = 1; a_instr = i0; a_pc = 32'h200;
      tick();
      a_instr = i1; a_pc = 32'h204;
      tick();
      a_instr = i2; a_pc = 32'h208;
      #1;
      check_eq("bp_full_in_ready", a_in_ready, 0);
      check_eq("bp_out_valid", a_out_valid, 1);
      check_eq("bp_head", a_instr_out, i0);
      tick();
      check_eq("bp_hold_instr", a_instr_out, i0);
      check_eq("bp_hold_pc", a_pc_out, 32'h200);
      check_eq("bp_hold_dec", a_dec, ref_onehot(i0, 1));
      check_eq("bp_hold_in_ready", a_in_ready, 0);
      a_out_ready = 1;
      #1 check_eq("bp_in_ready_on_pop", a_in_ready, 1);
      tick();
      a_in_valid = 0;
      check_eq("bp_order1", a_instr_out, i1);
      check_eq("bp_order1_dec", a_dec, ref_onehot(i1, 1));
      tick();
      check_eq("bp_order2", a_instr_out, i2);
      check_eq("bp_order2_pc", a_pc_out, 32'h208);
      check_eq("bp_order2_dec", a_dec, ref_onehot(i2, 1));
      tick();
      check_eq("bp_drained", a_out_valid, 0);
      check_eq("bp_dec_cnt", a_dec_cnt, 5);

      // Saturation with CNT_W=2, then clear beating an increment
      b_cnt_clr = 1;
      tick();
      b_cnt_clr = 0;
      check_eq("clr_dec_cnt", b_dec_cnt, 0);
      check_eq("clr_ill_cnt", b_ill_cnt, 0);
      b_instr = 32'h0022_1820; b_in_valid = 1; b_out_ready = 1;
      repeat (5) tick();
      b_in_valid = 0;
      tick();
      check_eq("sat_dec_cnt", b_dec_cnt, 3);
      check_eq("sat_ill_cnt", b_ill_cnt, 0);
      b_in_valid = 1;
      tick();
      b_in_valid = 0; b_cnt_clr = 1;
      check_eq("clr_hs_pending", b_out_valid, 1);
      tick();
      b_cnt_clr = 0;
      check_eq("clr_prio_dec_cnt", b_dec_cnt, 0);
      check_eq("clr_fifo_untouched", b_out_valid, 0);

      // Sweep every opcode x funct on both instances
      a_out_ready = 1; b_out_ready = 1; a_in_valid = 1; b_in_valid = 1;
      for (int op = 0; op < 64; op++) begin
         for (int fn = 0; fn < 64; fn++) begin
            w = {6'(op), 20'($urandom), 6'(fn)};
            a_instr = w; b_instr = w; a_pc = w ^ 32'h5a5a; b_pc = w;
            tick();
            check_eq("sweep_a_dec", a_dec, ref_onehot(w, 1));
            check_eq("sweep_a_ill", a_ill, ref_onehot(w, 1) == 0);
            check_eq("sweep_a_pop", $countones(a_dec) <= 1, 1);
            check_eq("sweep_a_instr", a_instr_out, w);
            check_eq("sweep_b_dec", b_dec, ref_onehot(w, 0));
            check_eq("sweep_b_ill", b_ill, ref_onehot(w, 0) == 0);
            check_eq("sweep_b_pop", $countones(b_dec) <= 1, 1);
         end
      end
      a_in_valid = 0; b_in_valid = 0;
      tick();
      check_eq("sweep_drained", a_out_valid, 0);

      // Asynchronous reset with two entries held
      a_out_ready = 0; a_in_valid = 1; a_instr = 32'h0022_1820;
      tick();
      tick();
      a_in_valid = 0;
      check_eq("pre_rst_full", a_out_valid, 1);
      #3 rst_n = 1'b0;
      #1;
      check_eq("arst_out_valid", a_out_valid, 0);
      check_eq("arst_in_ready", a_in_ready, 0);
      check_eq("arst_dec_cnt", a_dec_cnt, 0);
      check_eq("arst_ill_cnt", a_ill_cnt, 0);
      check_eq("arst_dec", a_dec, 0);
      check_eq("arst_instr_out", a_instr_out, 0);
      a_out_ready = 1;
      repeat (2) tick();
      check_eq("arst_hold_out_valid", a_out_valid, 0);
      #3 rst_n = 1'b1;
      tick();
      check_eq("post_rst_out_valid", a_out_valid, 0);
      check_eq("post_rst_in_ready", a_in_ready, 1);
      check_eq("post_rst_dec_cnt", a_dec_cnt, 0);

      // Randomized run against the scoreboard
      m_dec = 0; m_ill = 0;
      for (int c = 0; c < 1500; c++) begin
         a_in_valid  = ($urandom % 4) != 0;
         a_out_ready = ($urandom % 3) != 0;
         a_cnt_clr   = ($urandom % 64) == 0;
         w = $urandom;
         if ($urandom % 2) begin
            k = int'($urandom % 48);
            w[31:26] = 6'(tab_op[k]);
            if (tab_fn[k] >= 0) w[5:0] = 6'(tab_fn[k]);
         end
         a_instr = w; a_pc = $urandom;
         #1;
         check_eq("rnd_out_valid", a_out_valid, sb_q.size() != 0);
         check_eq("rnd_in_ready", a_in_ready, sb_q.size() < 2 || a_out_ready);
         if (sb_q.size() != 0) begin
            check_eq("rnd_dec", a_dec, sb_q[0].oh);
            check_eq("rnd_ill", a_ill, sb_q[0].ill);
            check_eq("rnd_instr", a_instr_out, sb_q[0].instr);
            check_eq("rnd_pc", a_pc_out, sb_q[0].pc);
         end
         check_eq("rnd_dec_cnt", a_dec_cnt, m_dec);
         check_eq("rnd_ill_cnt", a_ill_cnt, m_ill);
         hs_out = sb_q.size() != 0 && a_out_ready;
         hs_in  = a_in_valid && (sb_q.size() < 2 || a_out_ready);
         if (a_cnt_clr) begin
            m_dec = 0; m_ill = 0;
         end else if (hs_out) begin
            if (m_dec < 65535) m_dec++;
            if (sb_q[0].ill && m_ill < 65535) m_ill++;
         end
         if (hs_out) void'(sb_q.pop_front());
         if (hs_in) begin
            e.oh = ref_onehot(a_instr, 1);
            e.ill = (e.oh == 0);
            e.instr = a_instr;
            e.pc = a_pc;
            sb_q.push_back(e);
         end
         @(posedge clk);
         #1;
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
